// File: rtl/dmem_port_ctrl.sv
// Data-memory port controller: terminates the memory stage's dddr_* request
// and runs a waitrequest-style word bus toward data RAM, returning a one-cycle dddr_resp.
module dmem_port_ctrl #(
  parameter int unsigned ADDR_W   = 30,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dddr_addr,
  input  logic              dddr_read,
  input  logic              dddr_write,
  input  logic [31:0]       dddr_wdata,
  output logic [31:0]       dddr_rdata,
  output logic              dddr_resp,
  output logic              dddr_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_waitrequest,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rdvalid
);

  typedef enum logic [1:0] {IDLE, CMD, RDWAIT, RESP} state_t;

  // wait_cnt holds completed RDWAIT cycles, so the current cycle is wait_cnt+1
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        rd_q;
  logic        wr_q;
  logic        resp_q;
  logic        err_q;
  logic [15:0] wait_cnt;
  logic [31:0] rdata_aligned;

  assign rdata_aligned = mem_rdata >> {addr_q[1:0], 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      resp_q   <= 1'b0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      resp_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (dddr_read && dddr_write) begin
            state   <= RESP;
            resp_q  <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= ERR_DATA;
          end else if (dddr_write && (dddr_addr[1:0] != 2'b00)) begin
            state   <= RESP;
            resp_q  <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else if (dddr_read || dddr_write) begin
            state   <= CMD;
            addr_q  <= dddr_addr;
            wdata_q <= dddr_wdata;
            rd_q    <= dddr_read;
            wr_q    <= dddr_write;
          end
        end
        CMD: begin
          if (!mem_waitrequest) begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
            if (wr_q) begin
              state   <= RESP;
              resp_q  <= 1'b1;
              rdata_q <= '0;
            end else begin
              state    <= RDWAIT;
              wait_cnt <= '0;
            end
          end
        end
        RDWAIT: begin
          // a late rdvalid in the final allowed cycle still wins over the timeout
          if (mem_rdvalid) begin
            state    <= RESP;
            resp_q   <= 1'b1;
            rdata_q  <= rdata_aligned;
            wait_cnt <= '0;
          end else if (wait_cnt == TO_LAST) begin
            state    <= RESP;
            resp_q   <= 1'b1;
            err_q    <= 1'b1;
            rdata_q  <= ERR_DATA;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign dddr_rdata = rdata_q;
  assign dddr_resp  = resp_q;
  assign dddr_err   = err_q;
  assign mem_addr   = addr_q[ADDR_W+1:2];
  assign mem_read   = rd_q;
  assign mem_write  = wr_q;
  assign mem_wdata  = wdata_q;
  assign mem_be     = {4{rd_q | wr_q}};

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Directed bench for dmem_port_ctrl: a simple bus responder model drives the
// memory side, and a scoreboard checks every dddr_resp against queued expectations.
module tb_dmem_port_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dddr_addr;
  logic        dddr_read;
  logic        dddr_write;
  logic [31:0] dddr_wdata;
  logic [31:0] dddr_rdata;
  logic        dddr_resp;
  logic        dddr_err;
  logic [29:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_waitrequest;
  logic [31:0] mem_rdata;
  logic        mem_rdvalid;

  always #5 clk = ~clk;

  dmem_port_ctrl #(
    .ADDR_W  (30),
    .TIMEOUT (TO),
    .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .dddr_addr      (dddr_addr),
    .dddr_read      (dddr_read),
    .dddr_write     (dddr_write),
    .dddr_wdata     (dddr_wdata),
    .dddr_rdata     (dddr_rdata),
    .dddr_resp      (dddr_resp),
    .dddr_err       (dddr_err),
    .mem_addr       (mem_addr),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_wdata      (mem_wdata),
    .mem_be         (mem_be),
    .mem_waitrequest(mem_waitrequest),
    .mem_rdata      (mem_rdata),
    .mem_rdvalid    (mem_rdvalid)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk;
  } exp_t;

  exp_t        sb[$];
  exp_t        popped;
  int          tests = 0;
  int          fails = 0;
  int          resp_count = 0;

  int          bus_wait = 0;
  int          bus_rd_lat = 0;
  logic [31:0] bus_rdata = '0;
  int          cmd_seen = 0;
  int          cmd_cycles = 0;
  int          rd_delay = 0;
  logic [31:0] cap_addr = '0;
  logic [31:0] cap_wdata = '0;
  logic [3:0]  cap_be = '0;
  logic [1:0]  cap_op = '0;
  logic        unstable = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata,
                               input logic exp_err, input logic exp_chk);
    exp_t e;
    @(posedge clk);
    #1;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.chk   = exp_chk;
    sb.push_back(e);
    cmd_seen   = 0;
    unstable   = 1'b0;
    dddr_read  = rd;
    dddr_write = wr;
    dddr_addr  = addr;
    dddr_wdata = wdata;
  endtask

  task automatic runUntilResp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!dddr_resp && lat < 20);
    if (!dddr_resp) checkOutput("resp_wait", {31'b0, dddr_resp}, 32'd1);
    dddr_read  = 1'b0;
    dddr_write = 1'b0;
  endtask

  // Bus responder: holds waitrequest for bus_wait command cycles, then returns
  // read data bus_rd_lat cycles after acceptance (0 means never).
  initial begin
    mem_waitrequest = 1'b0;
    mem_rdvalid     = 1'b0;
    mem_rdata       = '0;
    forever begin
      @(negedge clk);
      mem_rdvalid = 1'b0;
      if (rd_delay > 0) begin
        rd_delay--;
        if (rd_delay == 0) begin
          mem_rdvalid = 1'b1;
          mem_rdata   = bus_rdata;
        end
      end
      if (mem_read || mem_write) begin
        if (cmd_cycles == 0) begin
          cap_addr  = {2'b00, mem_addr};
          cap_wdata = mem_wdata;
          cap_be    = mem_be;
          cap_op    = {mem_read, mem_write};
        end else if ({2'b00, mem_addr} != cap_addr || mem_wdata != cap_wdata ||
                     mem_be != cap_be || {mem_read, mem_write} != cap_op) begin
          unstable = 1'b1;
        end
        mem_waitrequest = (cmd_cycles < bus_wait);
        cmd_cycles++;
        cmd_seen++;
        if (!mem_waitrequest && mem_read) rd_delay = bus_rd_lat;
      end else begin
        mem_waitrequest = 1'b0;
        cmd_cycles      = 0;
      end
    end
  end

  // Scoreboard: every completion must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (dddr_resp) begin
        resp_count++;
        if (sb.size() == 0) begin
          checkOutput("unexpected_resp", {31'b0, dddr_resp}, 32'd0);
        end else begin
          popped = sb.pop_front();
          checkOutput("resp_err", {31'b0, dddr_err}, {31'b0, popped.err});
          if (popped.chk) checkOutput("resp_rdata", dddr_rdata, popped.rdata);
        end
      end else begin
        checkOutput("err_outside_resp", {31'b0, dddr_err}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int saved;
    rst        = 1'b1;
    dddr_read  = 1'b0;
    dddr_write = 1'b0;
    dddr_addr  = '0;
    dddr_wdata = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_resp", {31'b0, dddr_resp}, 32'd0);
    checkOutput("rst_rdata", dddr_rdata, 32'd0);
    checkOutput("rst_cmd", {30'b0, mem_read, mem_write}, 32'd0);
    checkOutput("rst_be", {28'b0, mem_be}, 32'd0);
    rst = 1'b0;

    // Aligned load, two-cycle read latency
    bus_wait = 0; bus_rd_lat = 2; bus_rdata = 32'h11223344;
    applyStimulus(1'b1, 1'b0, 32'h0000_0104, 32'h0, 32'h11223344, 1'b0, 1'b1);
    runUntilResp(lat);
    checkOutput("load_lat", lat, 32'd5);
    checkOutput("load_addr", cap_addr, 32'h41);
    checkOutput("load_be", {28'b0, cap_be}, 32'hF);
    checkOutput("load_op", {30'b0, cap_op}, 32'd2);
    checkOutput("load_cmd_cycles", cmd_seen, 32'd1);
    repeat (2) @(negedge clk);
    checkOutput("rdata_hold", dddr_rdata, 32'h11223344);

    // Byte-offset loads
    bus_rd_lat = 1; bus_rdata = 32'hAABBCCDD;
    applyStimulus(1'b1, 1'b0, 32'h0000_0107, 32'h0, 32'h0000_00AA, 1'b0, 1'b1);
    runUntilResp(lat);
    checkOutput("byte3_lat", lat, 32'd4);
    applyStimulus(1'b1, 1'b0, 32'h0000_0106, 32'h0, 32'h0000_AABB, 1'b0, 1'b1);
    runUntilResp(lat);
    checkOutput("half2_addr", cap_addr, 32'h41);
    bus_wait = 2;
    applyStimulus(1'b1, 1'b0, 32'h0000_0105, 32'h0, 32'h00AA_BBCC, 1'b0, 1'b1);
    runUntilResp(lat);
    checkOutput("byte1_wait_lat", lat, 32'd6);

    // Store held off by waitrequest; request inputs are scrambled mid-transaction
    bus_wait = 3;
    applyStimulus(1'b0, 1'b1, 32'h0000_0010, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    dddr_write = 1'b0;
    dddr_wdata = 32'h12345678;
    dddr_addr  = 32'h0000_0FF0;
    runUntilResp(lat);
    checkOutput("store_lat", lat, 32'd4);
    checkOutput("store_cmd_cycles", cmd_seen, 32'd4);
    checkOutput("store_addr", cap_addr, 32'h4);
    checkOutput("store_wdata", cap_wdata, 32'hCAFEF00D);
    checkOutput("store_be", {28'b0, cap_be}, 32'hF);
    checkOutput("store_op", {30'b0, cap_op}, 32'd1);
    checkOutput("store_stable", {31'b0, unstable}, 32'd0);

    // Misaligned store and illegal read+write never reach the bus
    bus_wait = 0;
    applyStimulus(1'b0, 1'b1, 32'h0000_0012, 32'h55AA55AA, 32'h0, 1'b1, 1'b1);
    runUntilResp(lat);
    checkOutput("misalign_lat", lat, 32'd2);
    checkOutput("misalign_no_cmd", cmd_seen, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0020, 32'h0, 32'hDEADBEEF, 1'b1, 1'b1);
    runUntilResp(lat);
    checkOutput("rdwr_lat", lat, 32'd2);
    checkOutput("rdwr_no_cmd", cmd_seen, 32'd0);

    // Read timeout, then rdvalid on the last allowed cycle
    bus_rd_lat = 0;
    applyStimulus(1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'hDEADBEEF, 1'b1, 1'b1);
    runUntilResp(lat);
    checkOutput("timeout_lat", lat, 32'd7);
    bus_rd_lat = TO; bus_rdata = 32'h55667788;
    applyStimulus(1'b1, 1'b0, 32'h0000_0202, 32'h0, 32'h0000_5566, 1'b0, 1'b1);
    runUntilResp(lat);
    checkOutput("edge_valid_lat", lat, 32'd7);

    // Reset during RDWAIT aborts the load; the late rdvalid must be ignored
    bus_rd_lat = 3; bus_rdata = 32'h99887766;
    applyStimulus(1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'h99887766, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    saved     = resp_count;
    rst       = 1'b1;
    dddr_read = 1'b0;
    #1;
    checkOutput("abort_rdata", dddr_rdata, 32'd0);
    checkOutput("abort_addr", {2'b00, mem_addr}, 32'd0);
    checkOutput("abort_cmd", {30'b0, mem_read, mem_write}, 32'd0);
    checkOutput("abort_resp", {31'b0, dddr_resp}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("abort_no_resp", resp_count, saved);

    bus_rd_lat = 1; bus_rdata = 32'h0BADF00D;
    applyStimulus(1'b1, 1'b0, 32'h0000_0304, 32'h0, 32'h0BADF00D, 1'b0, 1'b1);
    runUntilResp(lat);
    checkOutput("post_rst_lat", lat, 32'd4);
    checkOutput("post_rst_addr", cap_addr, 32'hC1);

    repeat (3) @(negedge clk);
    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_port_ctrl.md
Name: dmem_port_ctrl

Overview:
- Data-memory port controller that sits directly downstream of the pipeline memory stage.
- Terminates the memory stage's dddr_* request/response interface and turns it into a pipelined, waitrequest-style word bus toward data RAM/SDRAM.
- Latches each request, runs the bus handshake, realigns sub-word read data to bit 0, and returns a one-cycle dddr_resp the memory stage uses to complete loads and stores.
- Detects misaligned stores, illegal read+write requests and read timeouts.

Parameters:
- ADDR_W, 30, word-address width of the external bus (byte address bits [ADDR_W+1:2]).
- TIMEOUT, 255, max cycles waiting for mem_rdvalid after read acceptance before error completion (1..65535).
- ERR_DATA, 32'hDEADBEEF, value returned on dddr_rdata for an error completion.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- dddr_addr  in  32  byte address from memory stage.
- dddr_read  in  1  load request level.
- dddr_write  in  1  store request level.
- dddr_wdata  in  32  store data.
- dddr_rdata  out  32  load data, right-aligned by byte offset.
- dddr_resp  out  1  one-cycle completion pulse.
- dddr_err  out  1  valid with dddr_resp; completion was an error.
- mem_addr  out  ADDR_W  word address.
- mem_read  out  1  bus read command.
- mem_write  out  1  bus write command.
- mem_wdata  out  32  bus write data.
- mem_be  out  4  byte enables, always 4'hF when a command is active.
- mem_waitrequest  in  1  bus not accepting the command this cycle.
- mem_rdata  in  32  bus read data.
- mem_rdvalid  in  1  mem_rdata valid.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - All outputs 0.
  - Latches 0, timeout counter 0.
- States: IDLE, CMD, RDWAIT, RESP.
- IDLE:
  - If dddr_read^dddr_write, latch addr, wdata and op, then go to CMD next cycle.
  - If both are high, no bus access; go to RESP with err=1 and rdata=ERR_DATA.
  - A store with dddr_addr[1:0]!=0 gets no bus access; go to RESP with err=1 (rdata=0).
- CMD:
  - Drive mem_read or mem_write, mem_addr=latched addr[ADDR_W+1:2], mem_wdata, mem_be=4'hF.
  - Commands stay stable while mem_waitrequest=1.
  - Accepted on a cycle with mem_waitrequest=0.
  - Accepted read goes to RDWAIT; accepted write goes to RESP (err=0).
  - No timeout in CMD; commands are never withdrawn.
- RDWAIT:
  - Commands deasserted.
  - On mem_rdvalid, capture mem_rdata >> (8*addr[1:0]) (zero-filled), then go to RESP with err=0.
  - The counter increments each RDWAIT cycle. At count==TIMEOUT without rdvalid, go to RESP with err=1 and rdata=ERR_DATA.
  - mem_rdvalid in the same cycle as count==TIMEOUT counts as success.
  - Counter clears on leaving RDWAIT.
- RESP:
  - dddr_resp=1 for exactly one cycle; dddr_rdata and dddr_err are driven from registers.
  - Then return to IDLE.
  - dddr_rdata holds its value after RESP until the next completion. dddr_err is 0 outside RESP.
- Latency:
  - Store with no wait: 2 cycles from request to resp (IDLE, CMD, resp in the 3rd state cycle).
  - Load: CMD acceptance + bus read latency + 1.
- Request inputs are sampled only in IDLE. Changes or deassertion in CMD/RDWAIT/RESP are ignored; the latched transaction always completes.
- The hazard unit releases the pipeline stall on dddr_resp. A request still present in IDLE the cycle after RESP is treated as a new transaction.
- mem_rdvalid outside RDWAIT is ignored.
- Async rst mid-transaction:
  - Immediate return to IDLE with commands dropped.
  - No resp is generated for the aborted transaction.
  - The bus side is reset by the same rst.

Test Plan:
- Aligned load, addr=0x0000_0104, waitrequest 0, rdvalid 2 cycles after accept with mem_rdata=0x11223344 -> mem_addr=0x41, mem_read for 1 cycle, dddr_resp 1 cycle with rdata=0x11223344, err=0.
- Byte-offset load, addr=0x0000_0107, mem_rdata=0xAABBCCDD -> rdata=0x000000AA. With addr=0x...106 -> rdata=0x0000AABB.
- Store, addr=0x10, wdata=0xCAFEF00D, waitrequest high 3 cycles -> mem_write, mem_addr and mem_wdata stable for 4 cycles, be=4'hF, resp 1 cycle after acceptance, err=0.
- Misaligned store addr=0x12 -> no mem_write ever, resp+err in 2nd cycle. Read+write together -> no bus command, resp+err, rdata=0xDEADBEEF.
- Timeout with TIMEOUT=4, rdvalid never -> resp+err with rdata=0xDEADBEEF after 4 RDWAIT cycles. Repeat with rdvalid on the 4th cycle -> err=0, data captured.
- Assert rst during RDWAIT -> outputs 0 immediately. A late rdvalid after release produces no resp. A new load then completes normally.
